tsu_q_sched: RTL
================

// Module: tsu_q_sched
// PURPOSE
//  Round-robin drain scheduler for the RX and TX timestamp-unit queues.
//  Pops one 64-bit timestamp entry at a time from whichever queue holds data and presents it
//  on a single valid/ready stream tagged with its source.
//  Sits between the two tsu queue read ports and a host-side or DMA consumer.
//  Replaces per-queue polling through rgs.
// PARAMETERS
//  CNT_W     16   width of the per-source drained-entry counters (saturating)
//  STAT_W     8   width of the q_stat fill-level inputs
// PORTS
//  clk            in   1       single clock; q read clock and consumer clock
//  rst            in   1       synchronous, active-high reset
//  en_in          in   1       1 = scheduling enabled; 0 = finish current entry, then idle
//  rx_q_stat_in   in   STAT_W  RX queue fill level, 0 = empty
//  rx_q_data_in   in   64      RX queue read data, valid the cycle after rx_q_rd_en_out
//  rx_q_rd_en_out out  1       RX queue pop strobe, one-cycle pulse
//  tx_q_stat_in   in   STAT_W  TX queue fill level, 0 = empty
//  tx_q_data_in   in   64      TX queue read data, valid the cycle after tx_q_rd_en_out
//  tx_q_rd_en_out out  1       TX queue pop strobe, one-cycle pulse
//  ts_valid_out   out  1       output entry valid
//  ts_ready_in    in   1       consumer accepts the entry when valid & ready
//  ts_src_out     out  1       0 = RX, 1 = TX; stable while valid
//  ts_data_out    out  64      timestamp entry; stable while valid
//  rx_cnt_out     out  CNT_W   RX entries delivered, saturates at all-ones
//  tx_cnt_out     out  CNT_W   TX entries delivered, saturates at all-ones
//  busy_out       out  1       1 whenever state != IDLE
// BEHAVIOUR
//  - Reset values:
//    - state = IDLE; all outputs 0; rr_ptr = 0 (RX has priority first).
//  - FSM IDLE -> POP -> CAP -> OUT -> IDLE. All outputs are registered (Moore).
//  - IDLE:
//    - If en_in = 1 and any stat != 0, pick the source and go to POP.
//    - Source choice: if both queues are nonempty, pick rr_ptr (0 = RX); otherwise pick the nonempty one.
//  - POP:
//    - Assert the selected q_rd_en_out for exactly 1 cycle, then go to CAP.
//  - CAP:
//    - Register the selected q_data_in into ts_data_out and the source into ts_src_out.
//    - Go to OUT with ts_valid_out = 1.
//  - OUT:
//    - Hold data, src and valid until ts_ready_in = 1.
//    - On handshake: valid drops next cycle, the source counter increments (saturating), rr_ptr = ~src, state = IDLE.
//  - Latency: IDLE sees stat != 0 in cycle N -> rd_en in N+1 -> valid in N+3. Minimum 4 cycles per entry.
//  - At most one rd_en is ever outstanding; the two rd_en outputs are never high together.
//  - stat is only sampled in IDLE; the queue must reflect a pop within 2 cycles of rd_en.
//  - en_in deasserted in POP/CAP/OUT: the current entry completes normally; then stay IDLE.
//  - ts_ready_in held high in OUT: the handshake completes in the first OUT cycle.
//  - Counter at max: holds at all-ones and is not cleared except by rst.
//  - rst mid-operation: an entry already popped from a queue is discarded (not re-queued).
//    All state returns to reset values next cycle.
//  - Queue empty with stat = 0: no rd_en is ever issued (no underflow pop).
// TESTING
//  - Reset, en=1, rx stat=1 with data 64'hA5 -> rx_rd_en pulse at N+1; valid, src=0, data=A5 at N+3; rx_cnt=1.
//  - Both stat=3, ready=1 constantly -> sources alternate RX,TX,RX,TX,RX,TX; rx_cnt=3, tx_cnt=3; never both rd_en.
//  - TX entry in OUT, ready=0 for 10 cycles -> data/src/valid stable, no further rd_en, tx_cnt unchanged until ready.
//  - en=0 during POP -> entry still delivered, then busy=0 and no rd_en while stat stays nonzero.
//  - rst asserted in CAP -> next cycle valid=0, busy=0, counters=0, rr_ptr=0; the popped entry is not output.
//  - CNT_W=2, deliver 5 RX entries -> rx_cnt sequence 1,2,3,3,3.

Source files
------------

// File: rtl/tsu_q_sched.sv
// Round-robin drain scheduler for the RX/TX timestamp-unit queues: pops one 64-bit entry at a
// time and presents it on a single valid/ready stream tagged with its source.
module tsu_q_sched #(
   parameter int CNT_W  = 16,
   parameter int STAT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_in,
   input  logic [STAT_W-1:0] rx_q_stat_in,
   input  logic [63:0]       rx_q_data_in,
   output logic              rx_q_rd_en_out,
   input  logic [STAT_W-1:0] tx_q_stat_in,
   input  logic [63:0]       tx_q_data_in,
   output logic              tx_q_rd_en_out,
   output logic              ts_valid_out,
   input  logic              ts_ready_in,
   output logic              ts_src_out,
   output logic [63:0]       ts_data_out,
   output logic [CNT_W-1:0]  rx_cnt_out,
   output logic [CNT_W-1:0]  tx_cnt_out,
   output logic              busy_out
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_POP  = 2'd1,
      ST_CAP  = 2'd2,
      ST_OUT  = 2'd3
   } state_t;

   state_t             state_r;
   logic               rr_ptr_r;
   logic               sel_r;
   logic               rx_rd_en_r;
   logic               tx_rd_en_r;
   logic               valid_r;
   logic               src_r;
   logic [63:0]        data_r;
   logic [CNT_W-1:0]   rx_cnt_r;
   logic [CNT_W-1:0]   tx_cnt_r;
   logic               busy_r;

   logic               rx_ne_s;
   logic               tx_ne_s;
   logic               start_s;
   logic               pick_s;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v) begin
         return v;
      end else begin
         return v + CNT_W'(1);
      end
   endfunction

   assign rx_ne_s = |rx_q_stat_in;
   assign tx_ne_s = |tx_q_stat_in;
   assign start_s = en_in & (rx_ne_s | tx_ne_s);

   // Source choice: round-robin pointer breaks ties, otherwise the only nonempty queue wins.
   always_comb begin
      pick_s = 1'b0;
      if (rx_ne_s && tx_ne_s) begin
         pick_s = rr_ptr_r;
      end else if (tx_ne_s) begin
         pick_s = 1'b1;
      end else begin
         pick_s = 1'b0;
      end
   end

   // Scheduler FSM; every output is a register updated on the state transition that owns it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         rr_ptr_r   <= 1'b0;
         sel_r      <= 1'b0;
         rx_rd_en_r <= 1'b0;
         tx_rd_en_r <= 1'b0;
         valid_r    <= 1'b0;
         src_r      <= 1'b0;
         data_r     <= 64'h0;
         rx_cnt_r   <= {CNT_W{1'b0}};
         tx_cnt_r   <= {CNT_W{1'b0}};
         busy_r     <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start_s) begin
                  sel_r      <= pick_s;
                  rx_rd_en_r <= ~pick_s;
                  tx_rd_en_r <= pick_s;
                  busy_r     <= 1'b1;
                  state_r    <= ST_POP;
               end else begin
                  state_r    <= ST_IDLE;
               end
            end
            ST_POP: begin
               rx_rd_en_r <= 1'b0;
               tx_rd_en_r <= 1'b0;
               state_r    <= ST_CAP;
            end
            ST_CAP: begin
               // Queue read data is valid exactly one cycle after the pop strobe.
               data_r  <= sel_r ? tx_q_data_in : rx_q_data_in;
               src_r   <= sel_r;
               valid_r <= 1'b1;
               state_r <= ST_OUT;
            end
            ST_OUT: begin
               if (ts_ready_in) begin
                  valid_r  <= 1'b0;
                  rr_ptr_r <= ~src_r;
                  busy_r   <= 1'b0;
                  state_r  <= ST_IDLE;
                  if (src_r) begin
                     tx_cnt_r <= sat_inc(tx_cnt_r);
                  end else begin
                     rx_cnt_r <= sat_inc(rx_cnt_r);
                  end
               end else begin
                  state_r <= ST_OUT;
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               rx_rd_en_r <= 1'b0;
               tx_rd_en_r <= 1'b0;
               valid_r    <= 1'b0;
               busy_r     <= 1'b0;
            end
         endcase
      end
   end

   assign rx_q_rd_en_out = rx_rd_en_r;
   assign tx_q_rd_en_out = tx_rd_en_r;
   assign ts_valid_out   = valid_r;
   assign ts_src_out     = src_r;
   assign ts_data_out    = data_r;
   assign rx_cnt_out     = rx_cnt_r;
   assign tx_cnt_out     = tx_cnt_r;
   assign busy_out       = busy_r;

endmodule
